uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: FIFO_DEPTH, 16, TX FIFO entries (power of 2).
REQ-002 Parameter: DATA_W, 8, data bits per frame.
REQ-003 pclk  input  1  single clock; all state changes on rising edge.
REQ-004 preset_n  input  1  reset, synchronous, active-low.
REQ-005 ctrl_en  input  1  UART enable; 0 aborts any frame in progress and blocks new frames.
REQ-006 ctrl_tx_en  input  1  one-cycle write strobe pushing ctrl_data into the TX FIFO.
REQ-007 ctrl_data  input  8  byte to transmit, sampled when ctrl_tx_en=1.
REQ-008 ctrl_d9  input  1  1 = append parity bit after data.
REQ-009 ctrl_ep  input  1  parity select: 1 = even, 0 = odd.
REQ-010 ctrl_shift_tx  input  1  one-cycle bit-time tick.
REQ-011 ctrl_txt  input  2  TX FIFO empty-threshold select.
REQ-012 tx_nf  output  1  FIFO not full.
REQ-013 tx_busy  output  1  FSM not IDLE.
REQ-014 tx_txe  output  1  FIFO level at or below threshold.
REQ-015 uart_tx  output  1  serial line, idle high.

Function
REQ-016 FIFO shall accept ctrl_data when ctrl_tx_en=1 and not full; a write while full with no same-cycle pop shall be dropped, with no change to FIFO contents or count.
REQ-017 A write and a pop in the same cycle shall both take effect, including at full (count unchanged) and at count 1.
REQ-018 FIFO pointers shall wrap modulo FIFO_DEPTH; count width shall be log2(FIFO_DEPTH)+1.
REQ-019 tx_nf shall be 1 iff count < FIFO_DEPTH, combinational from count.
REQ-020 tx_txe shall be 1 iff count <= threshold, combinational from count: ctrl_txt 00 -> 0, 01 -> 4, 10 -> 8, 11 -> 12.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP; every transition shall occur only on a cycle with ctrl_shift_tx=1, except the abort in REQ-026.
REQ-022 IDLE -> START when ctrl_en=1, FIFO non-empty and ctrl_shift_tx=1: pop FIFO head into shift register the same cycle and drive uart_tx=0 from the next cycle.
REQ-023 START -> DATA; DATA shall output bits LSB first, one per tick, with an internal 3-bit bit counter; after bit 7, go to PARITY if ctrl_d9=1, else to STOP.
REQ-024 PARITY shall drive the XOR of the 8 data bits when ctrl_ep=1, and its inverse when ctrl_ep=0; then go to STOP.
REQ-025 STOP shall drive 1 for one tick; on that tick, go to START with a new pop if ctrl_en=1 and FIFO non-empty (back-to-back), else go to IDLE.
REQ-026 ctrl_en=0 in any state shall force IDLE and uart_tx=1 on the next cycle; the FIFO is retained and the partial byte is discarded.
REQ-027 ctrl_d9 and ctrl_ep shall be sampled at pop time and held for the whole frame.
REQ-028 uart_tx shall be registered (no combinational path from inputs).

Reset
REQ-029 On preset_n=0 at a clock edge: FIFO empty, pointers 0, FSM IDLE, uart_tx=1, tx_busy=0, tx_nf=1, tx_txe=1.
REQ-030 Reset mid-frame shall abort immediately; FIFO contents shall be lost.

Structure
REQ-031 FSM state encodings, FIFO_DEPTH and threshold constants shall live in the shared uart define header.
REQ-032 The FIFO shall be a sub-module, uart_fifo (synchronous, parameterised width/depth, push/pop/full/empty/count).
REQ-033 The transmitter top shall contain only the FSM, shift register, parity logic and threshold compare.

Verification
REQ-034 ctrl_en=1, ctrl_d9=0, write 0xA5, ticks every 16 cycles -> uart_tx frame 0,1,0,1,0,0,1,0,1,1; tx_busy=1 throughout, then 0.
REQ-035 ctrl_d9=1, ctrl_ep=1, write 0xA5 -> parity bit 0; with ctrl_ep=0 -> parity bit 1; frame length 11 ticks.
REQ-036 With ctrl_en=0, write 17 bytes -> tx_nf=0 after the 16th write; the 17th is dropped; enable -> exactly 16 frames, back-to-back with no idle tick between them.
REQ-037 ctrl_txt=01, load 6 bytes -> tx_txe=0; after the 2nd pop -> tx_txe=1; with ctrl_txt=00, tx_txe=1 only at count 0.
REQ-038 Deassert ctrl_en during DATA bit 3 -> uart_tx=1, tx_busy=0 on the next cycle; remaining FIFO bytes are sent after re-enable. Repeat with preset_n=0 -> FIFO empty.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// uart_transmitter_pkg: shared constants, FSM encodings and threshold helper
package uart_transmitter_pkg;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_DATA_W = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;
  function automatic int unsigned txe_threshold(input logic [1:0] txt);
    return 32'(txt) << 2;
  endfunction
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: control and status bundle between host and transmitter
interface uart_transmitter_if import uart_transmitter_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic ctrl_en;
  logic ctrl_tx_en;
  logic [DATA_W-1:0] ctrl_data;
  logic ctrl_d9;
  logic ctrl_ep;
  logic ctrl_shift_tx;
  logic [1:0] ctrl_txt;
  logic tx_nf;
  logic tx_busy;
  logic tx_txe;
  logic uart_tx;
  modport master (
    output ctrl_en, ctrl_tx_en, ctrl_data, ctrl_d9, ctrl_ep, ctrl_shift_tx, ctrl_txt,
    input tx_nf, tx_busy, tx_txe, uart_tx
  );
  modport slave (
    input ctrl_en, ctrl_tx_en, ctrl_data, ctrl_d9, ctrl_ep, ctrl_shift_tx, ctrl_txt,
    output tx_nf, tx_busy, tx_txe, uart_tx
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; a push while full is accepted only alongside a pop
module uart_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input logic pclk,
  input logic preset_n,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  // pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; emptiness is defined by count
  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-fed UART TX with optional parity, ticked by ctrl_shift_tx
module uart_transmitter import uart_transmitter_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic pclk,
  input logic preset_n,
  uart_transmitter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST = 3'(DATA_W - 1);
  logic [CW-1:0] count;
  logic full, empty, pop;
  logic [DATA_W-1:0] head, shreg;
  logic [2:0] state, bit_cnt;
  logic d9_q, par_q, tx_q;
  uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .pclk(pclk),
    .preset_n(preset_n),
    .push(bus.ctrl_tx_en),
    .pop(pop),
    .din(bus.ctrl_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign pop = bus.ctrl_en && bus.ctrl_shift_tx && !empty && (state == S_IDLE || state == S_STOP);
  assign bus.tx_nf = !full;
  assign bus.tx_busy = state != S_IDLE;
  assign bus.tx_txe = 32'(count) <= txe_threshold(bus.ctrl_txt);
  assign bus.uart_tx = tx_q;
  // frame sequencer: a pop loads the byte and frame options, each tick advances one bit
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state <= S_IDLE;
      tx_q <= 1'b1;
      bit_cnt <= '0;
      shreg <= '0;
      d9_q <= 1'b0;
      par_q <= 1'b0;
    end else if (!bus.ctrl_en) begin
      state <= S_IDLE;
      tx_q <= 1'b1;
    end else if (pop) begin
      state <= S_START;
      tx_q <= 1'b0;
      shreg <= head;
      d9_q <= bus.ctrl_d9;
      par_q <= ^head ^ ~bus.ctrl_ep;
    end else if (bus.ctrl_shift_tx) begin
      case (state)
        S_START: begin
          state <= S_DATA;
          tx_q <= shreg[0];
          shreg <= shreg >> 1;
          bit_cnt <= '0;
        end
        S_DATA: begin
          if (bit_cnt == LAST) begin
            state <= d9_q ? S_PARITY : S_STOP;
            tx_q <= d9_q ? par_q : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_q <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        S_PARITY: begin
          state <= S_STOP;
          tx_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          tx_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed and random frames checked against a queue-based line model
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  byte unsigned fifo_q[$];
  bit exp_q[$];
  always #5 clk = ~clk;
  uart_transmitter_if bus ();
  uart_transmitter dut (.pclk(clk), .preset_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag);
    chk({tag, " tx_nf"}, bus.tx_nf, fifo_q.size() < 16);
    chk({tag, " tx_txe"}, bus.tx_txe, fifo_q.size() <= int'(bus.ctrl_txt) * 4);
  endtask

  function automatic void add_frame(input byte unsigned d, input bit d9, input bit ep);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (d9) exp_q.push_back(ep ? ^d : ~^d);
    exp_q.push_back(1'b1);
  endfunction

  task automatic write(input byte unsigned d);
    bus.ctrl_data = d;
    bus.ctrl_tx_en = 1'b1;
    @(negedge clk);
    bus.ctrl_tx_en = 1'b0;
    if (fifo_q.size() < 16) fifo_q.push_back(d);
    status("write");
  endtask

  task automatic tick(input bit wr = 1'b0, input byte unsigned d = 8'h00);
    bit exp_tx, exp_busy;
    bus.ctrl_shift_tx = 1'b1;
    bus.ctrl_tx_en = wr;
    bus.ctrl_data = d;
    if (bus.ctrl_en && exp_q.size() == 0 && fifo_q.size() > 0)
      add_frame(fifo_q.pop_front(), bus.ctrl_d9, bus.ctrl_ep);
    if (wr && fifo_q.size() < 16) fifo_q.push_back(d);
    exp_tx = 1'b1;
    exp_busy = 1'b0;
    if (exp_q.size() > 0) begin
      exp_tx = exp_q.pop_front();
      exp_busy = 1'b1;
    end
    @(negedge clk);
    bus.ctrl_shift_tx = 1'b0;
    bus.ctrl_tx_en = 1'b0;
    chk("tick uart_tx", bus.uart_tx, exp_tx);
    chk("tick tx_busy", bus.tx_busy, exp_busy);
    status("tick");
    bus.ctrl_d9 = 1'($urandom);
    bus.ctrl_ep = 1'($urandom);
    repeat (15) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < 400) begin
      tick();
      n++;
    end
    chk("drain within bound", n < 400, 1'b1);
    tick();
  endtask

  initial begin
    bus.ctrl_en = 1'b0;
    bus.ctrl_tx_en = 1'b0;
    bus.ctrl_data = '0;
    bus.ctrl_d9 = 1'b0;
    bus.ctrl_ep = 1'b0;
    bus.ctrl_shift_tx = 1'b0;
    bus.ctrl_txt = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset uart_tx", bus.uart_tx, 1'b1);
    chk("reset tx_busy", bus.tx_busy, 1'b0);
    status("reset");
    rst_n = 1'b1;
    bus.ctrl_en = 1'b1;
    // plain 8N1 frame of 0xA5
    bus.ctrl_d9 = 1'b0;
    write(8'hA5);
    drain();
    // even then odd parity on 0xA5
    bus.ctrl_d9 = 1'b1;
    bus.ctrl_ep = 1'b1;
    write(8'hA5);
    drain();
    bus.ctrl_d9 = 1'b1;
    bus.ctrl_ep = 1'b0;
    write(8'hA5);
    drain();
    // random bytes, thresholds and per-frame options
    for (int i = 0; i < 6; i++) begin
      bus.ctrl_txt = 2'($urandom);
      write(8'($urandom));
    end
    drain();
    // fill while disabled, 17th write dropped, then 16 back-to-back frames
    bus.ctrl_en = 1'b0;
    bus.ctrl_txt = 2'b11;
    for (int i = 0; i < 17; i++) write(8'($urandom));
    bus.ctrl_en = 1'b1;
    drain();
    // simultaneous write and pop at full, then at count 1
    bus.ctrl_en = 1'b0;
    for (int i = 0; i < 16; i++) write(8'($urandom));
    bus.ctrl_en = 1'b1;
    tick(1'b1, 8'h3C);
    drain();
    bus.ctrl_en = 1'b0;
    write(8'h81);
    bus.ctrl_en = 1'b1;
    tick(1'b1, 8'h7E);
    drain();
    // threshold 4 with 6 queued, then threshold 0
    bus.ctrl_en = 1'b0;
    bus.ctrl_txt = 2'b01;
    for (int i = 0; i < 6; i++) write(8'($urandom));
    bus.ctrl_en = 1'b1;
    for (int i = 0; i < 24; i++) tick();
    bus.ctrl_txt = 2'b00;
    drain();
    // abort during data bit 3, remaining bytes follow after re-enable
    bus.ctrl_en = 1'b0;
    for (int i = 0; i < 3; i++) write(8'($urandom));
    bus.ctrl_en = 1'b1;
    bus.ctrl_d9 = 1'b0;
    repeat (5) tick();
    bus.ctrl_en = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("abort uart_tx", bus.uart_tx, 1'b1);
    chk("abort tx_busy", bus.tx_busy, 1'b0);
    status("abort");
    bus.ctrl_en = 1'b1;
    drain();
    // reset mid-frame empties the FIFO
    bus.ctrl_en = 1'b0;
    for (int i = 0; i < 3; i++) write(8'($urandom));
    bus.ctrl_en = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    fifo_q.delete();
    exp_q.delete();
    chk("midreset uart_tx", bus.uart_tx, 1'b1);
    chk("midreset tx_busy", bus.tx_busy, 1'b0);
    status("midreset");
    rst_n = 1'b1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
